approx_mult_err_monitor: RTL and testbench
==========================================

Name: approx_mult_err_monitor

Overview:
- Sequential error-metric accumulator for the 8-bit approximate multiplier.
- Consumes a valid/ready stream of (a, b, approximate product) samples, computes the exact product and the absolute error in hardware, and accumulates run statistics.
- Statistics: sample count, total absolute error, count of erroneous samples, maximum error and the operands that produced it.
- Sits beside the multiplier as an on-chip monitor, so error characterisation no longer depends on the simulator.

Parameters:
- WIDTH, 8, operand width; product and error are 2*WIDTH bits.
- CNT_W, 17, counter width; holds 65536, the exhaustive 8-bit sweep.
- SUM_W, 33, total-absolute-error accumulator width (2*WIDTH + CNT_W).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; clears statistics and begins a run.
- in_valid  in  1  sample valid.
- in_ready  out  1  monitor accepts the sample this cycle.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_approx  in  2*WIDTH  approximate product under test.
- in_last  in  1  marks the final sample of a run.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; results are stable.
- total_tests  out  CNT_W  accepted sample count.
- total_abs_err  out  SUM_W  sum of |exact - approx|.
- err_cases  out  CNT_W  samples with nonzero error.
- max_abs_err  out  2*WIDTH  largest absolute error seen.
- max_err_a  out  WIDTH  operand a of the max-error sample.
- max_err_b  out  WIDTH  operand b of the max-error sample.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE, pipeline valids 0, every output 0 (in_ready, busy, done and all statistics).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DRAIN on acceptance of a sample with in_last=1.
  - DRAIN -> DONE once both pipeline stages are empty.
  - DONE -> RUN on start.
  - start in RUN or DRAIN is ignored.
  - Entering RUN clears all statistics in the same cycle as start.
- Handshake:
  - in_ready = (state==RUN).
  - A sample is accepted when in_valid && in_ready.
  - in_valid may be held while in_ready is low without loss; the producer holds data stable.
  - No backpressure exists downstream.
- Pipeline, 2 stages:
  - S1 registers a, b, approx and exact = a*b (unsigned, 2*WIDTH bits).
  - S2 computes abs_err = (exact >= approx) ? exact-approx : approx-exact and updates statistics.
  - Statistics reflect a sample 2 cycles after acceptance.
  - done rises 3 cycles after acceptance of the last sample: S1 at +1, S2 update at +2, DONE visible at +3.
- Arithmetic:
  - All operands are unsigned.
  - total_tests, err_cases and total_abs_err saturate at all-ones and do not wrap.
  - err_cases increments when abs_err != 0.
  - max_abs_err updates only on a strictly greater error, so ties keep the first occurrence; max_err_a and max_err_b update with it.
- Boundary conditions:
  - A zero-error run leaves max_abs_err=0 and max_err_a/max_err_b=0.
  - A 0*0 sample counts toward total_tests.
  - A single-sample run (first sample has in_last=1) is legal.
  - in_valid while not in RUN is ignored.
  - start and an accepted in_last in the same cycle: the start is ignored (state is RUN).
  - Reset mid-run discards the pipeline and all statistics immediately.
- Outputs are registered and hold their values in DONE until the next start.

Test Plan:
- Reset mid-run: assert rst_n low after 10 samples in RUN -> all outputs 0 asynchronously, state IDLE, no done.
- Exact stream: start, then samples (3,5,15), (255,255,65025), (0,7,0) with last on the third -> total_tests=3, total_abs_err=0, err_cases=0, max_abs_err=0, done 3 cycles after the last acceptance.
- Error mix: samples (10,10,96), (12,12,150), (200,2,392) with last -> abs errors 4, 6, 8; total_abs_err=18, err_cases=3, max_abs_err=8, max_err_a=200, max_err_b=2.
- Tie and backpressure: (4,4,20) then (5,5,21), both error 4; toggle in_valid low for 2 cycles between them -> max_err_a=4, max_err_b=4, total_tests=2, no lost or duplicated sample.
- Exhaustive sweep: all 65536 (a,b) pairs, approx from the multiplier, last on (255,255) -> total_tests=65536 and total_abs_err equal to the bench model's sum; start issued during RUN is ignored.
- Restart: in DONE pulse start -> statistics clear the same cycle, busy=1, done=0; a new one-sample run (2,3,7) gives total_tests=1, total_abs_err=1.

Source files
------------

// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for an approximate multiplier: 2-stage pipeline (S1 operands/exact, S2 statistics).
// Latency: statistics reflect a sample 2 cycles after acceptance, done 3 cycles after the last one.
// Backpressure: in_ready is high only in RUN; there is no downstream backpressure.
module approx_mult_err_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 17,
    parameter int SUM_W = 33
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2*WIDTH-1:0]   in_approx,
    input  logic                 in_last,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     total_tests,
    output logic [SUM_W-1:0]     total_abs_err,
    output logic [CNT_W-1:0]     err_cases,
    output logic [2*WIDTH-1:0]   max_abs_err,
    output logic [WIDTH-1:0]     max_err_a,
    output logic [WIDTH-1:0]     max_err_b
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              clear_stats;
    logic              s1_vld;
    logic [WIDTH-1:0]  s1_a, s1_b;
    logic [PW-1:0]     s1_approx, s1_exact;
    logic [PW-1:0]     abs_err;
    logic [SUM_W:0]    sum_ext;

    assign accept      = in_valid && in_ready;
    assign clear_stats = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)              state_nxt = RUN;
            RUN:     if (accept && in_last)  state_nxt = DRAIN;
            DRAIN:   if (!s1_vld)            state_nxt = DONE;
            DONE:    if (start)              state_nxt = RUN;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == RUN);
        busy     = (state == RUN) || (state == DRAIN);
        done     = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_approx <= '0;
            s1_exact  <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_a      <= in_a;
                s1_b      <= in_b;
                s1_approx <= in_approx;
                s1_exact  <= PW'(in_a) * PW'(in_b);
            end
        end
    end

    assign abs_err = (s1_exact >= s1_approx) ? (s1_exact - s1_approx) : (s1_approx - s1_exact);
    // One extra bit catches the carry out so the accumulator can pin at all-ones.
    assign sum_ext = {1'b0, total_abs_err} + (SUM_W+1)'(abs_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_tests   <= '0;
            total_abs_err <= '0;
            err_cases     <= '0;
            max_abs_err   <= '0;
            max_err_a     <= '0;
            max_err_b     <= '0;
        end else if (clear_stats) begin
            total_tests   <= '0;
            total_abs_err <= '0;
            err_cases     <= '0;
            max_abs_err   <= '0;
            max_err_a     <= '0;
            max_err_b     <= '0;
        end else if (s1_vld) begin
            if (total_tests != '1)
                total_tests <= total_tests + CNT_W'(1);
            total_abs_err <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            if ((abs_err != '0) && (err_cases != '1))
                err_cases <= err_cases + CNT_W'(1);
            // Strictly greater: ties keep the operands of the first occurrence.
            if (abs_err > max_abs_err) begin
                max_abs_err <= abs_err;
                max_err_a   <= s1_a;
                max_err_b   <= s1_b;
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed self-checking bench for approx_mult_err_monitor.
module tb_approx_mult_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a, in_b;
    logic [15:0] in_approx;
    logic        in_last;
    logic        busy, done;
    logic [16:0] total_tests, err_cases;
    logic [32:0] total_abs_err;
    logic [15:0] max_abs_err;
    logic [7:0]  max_err_a, max_err_b;

    int checks = 0;
    int errors = 0;

    approx_mult_err_monitor #(.WIDTH(8), .CNT_W(17), .SUM_W(33)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .in_last(in_last),
        .busy(busy), .done(done), .total_tests(total_tests), .total_abs_err(total_abs_err),
        .err_cases(err_cases), .max_abs_err(max_abs_err), .max_err_a(max_err_a), .max_err_b(max_err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a, b;
        logic [15:0] approx;
        logic        last;
        int          exp_tests;
        longint      exp_sum;
        int          exp_errc;
        int          exp_max;
        int          exp_ma, exp_mb;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_in_ready"}, in_ready, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_tests"}, total_tests, 0);
        chk({name, "_sum"}, total_abs_err, 0);
        chk({name, "_errc"}, err_cases, 0);
        chk({name, "_max"}, max_abs_err, 0);
        chk({name, "_max_a"}, max_err_a, 0);
        chk({name, "_max_b"}, max_err_b, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Presents one sample and returns #1 after the edge that accepted it.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] approx, input logic last);
        int n = 0;
        @(negedge clk);
        in_a = a; in_b = b; in_approx = approx; in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called one cycle after the last acceptance: stats at +2, done at +3.
    task automatic finish_run(input string name, input int tests, input longint sum, input int errc,
                              input int mx, input int ma, input int mb);
        chk({name, "_done_p1"}, done, 0);
        @(posedge clk); #1;
        chk({name, "_done_p2"}, done, 0);
        chk({name, "_tests"}, total_tests, tests);
        chk({name, "_sum"}, total_abs_err, sum);
        chk({name, "_errc"}, err_cases, errc);
        chk({name, "_max"}, max_abs_err, mx);
        chk({name, "_max_a"}, max_err_a, ma);
        chk({name, "_max_b"}, max_err_b, mb);
        @(posedge clk); #1;
        chk({name, "_done_p3"}, done, 1);
        chk({name, "_busy_p3"}, busy, 0);
    endtask

    initial begin
        longint      sw_sum;
        int          sw_errc, sw_max, sw_ma, sw_mb;
        logic [15:0] ex, ap;

        vecs[0] = '{8'd3,   8'd5,   16'd15,    1'b0, 0, 0,  0, 0, 0,   0};
        vecs[1] = '{8'd255, 8'd255, 16'd65025, 1'b0, 0, 0,  0, 0, 0,   0};
        vecs[2] = '{8'd0,   8'd7,   16'd0,     1'b1, 3, 0,  0, 0, 0,   0};
        vecs[3] = '{8'd10,  8'd10,  16'd96,    1'b0, 0, 0,  0, 0, 0,   0};
        vecs[4] = '{8'd12,  8'd12,  16'd150,   1'b0, 0, 0,  0, 0, 0,   0};
        vecs[5] = '{8'd200, 8'd2,   16'd392,   1'b1, 3, 18, 3, 8, 200, 2};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; in_approx = '0;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // valid in IDLE is not accepted
        @(negedge clk);
        in_a = 8'd3; in_b = 8'd3; in_approx = 16'd1; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle_in_ready", in_ready, 0);
        chk("idle_tests", total_tests, 0);
        in_valid = 1'b0;

        // reset mid-run
        pulse_start();
        for (int i = 0; i < 10; i++) send(8'(i + 1), 8'd2, 16'd0, 1'b0);
        @(posedge clk); #1;
        chk("prereset_tests", total_tests, 10);
        chk("prereset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrun_reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("post_reset_tests", total_tests, 0);
        chk("post_reset_done", done, 0);

        // exact stream and error mix from the vector table
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || vecs[i-1].last) pulse_start();
            send(vecs[i].a, vecs[i].b, vecs[i].approx, vecs[i].last);
            if (vecs[i].last)
                finish_run($sformatf("vec%0d", i), vecs[i].exp_tests, vecs[i].exp_sum,
                           vecs[i].exp_errc, vecs[i].exp_max, vecs[i].exp_ma, vecs[i].exp_mb);
        end

        // tie keeps first occurrence, gap in in_valid
        pulse_start();
        send(8'd4, 8'd4, 16'd20, 1'b0);
        repeat (2) @(posedge clk);
        send(8'd5, 8'd5, 16'd21, 1'b1);
        finish_run("tie", 2, 8, 2, 4, 4, 4);

        // valid in DONE is ignored and results hold
        @(negedge clk);
        in_a = 8'd9; in_b = 8'd9; in_approx = 16'd0; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("done_hold_tests", total_tests, 2);
        chk("done_hold_done", done, 1);
        in_valid = 1'b0;

        // exhaustive sweep; approximate multiplier drops the low nibble
        sw_sum = 0; sw_errc = 0; sw_max = 0; sw_ma = 0; sw_mb = 0;
        pulse_start();
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                ex = 16'(a * b);
                ap = ex & 16'hFFF0;
                sw_sum += longint'(ex - ap);
                if (ex != ap) sw_errc++;
                if (int'(ex - ap) > sw_max) begin
                    sw_max = int'(ex - ap); sw_ma = a; sw_mb = b;
                end
                if ((a == 100 && b == 0) || (a == 255 && b == 255)) start = 1'b1;
                send(8'(a), 8'(b), ap, (a == 255 && b == 255));
                start = 1'b0;
            end
        end
        finish_run("sweep", 65536, sw_sum, sw_errc, sw_max, sw_ma, sw_mb);

        // restart from DONE with a sample already waiting
        @(negedge clk);
        in_a = 8'd2; in_b = 8'd3; in_approx = 16'd7; in_last = 1'b1; in_valid = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_done", done, 0);
        chk("restart_tests", total_tests, 0);
        chk("restart_sum", total_abs_err, 0);
        chk("restart_max", max_abs_err, 0);
        chk("restart_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
        finish_run("restart", 1, 1, 1, 1, 2, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
